// File: rtl/dram_pkg.sv
// Shared types and widths for the asynchronous DRAM controller.
package dram_pkg;

    localparam int ROW_W  = 10;
    localparam int COL_W  = 10;
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        COL,
        PRE,
        RCAS,
        RRAS,
        RPRE
    } state_t;

    // Active-low {ucas_n, lcas_n} for an access: reads open both lanes.
    function automatic logic [1:0] cas_lanes(input logic rnw, input logic [1:0] bsel);
        return rnw ? 2'b00 : ~bsel;
    endfunction

endpackage

// File: rtl/dram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
module dram_refresh_timer #(
    parameter int REFRESH_PERIOD = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic ref_pend
);

    localparam int CNT_W = $clog2(REFRESH_PERIOD);

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = (cnt == '0);

    // An expiry wins over a same-clock clear so a refresh is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= CNT_W'(REFRESH_PERIOD - 1);
            ref_pend <= 1'b0;
        end else begin
            cnt <= expire ? CNT_W'(REFRESH_PERIOD - 1) : cnt - CNT_W'(1);
            if (expire)
                ref_pend <= 1'b1;
            else if (clr)
                ref_pend <= 1'b0;
        end
    end

endmodule

// File: rtl/dram_ctrl.sv
// Request/acknowledge to RAS/CAS/WE sequencer for a 1M x 16 asynchronous DRAM,
// including CAS-before-RAS refresh.
module dram_ctrl
    import dram_pkg::*;
#(
    parameter int RAS_CYC        = 2,
    parameter int CAS_CYC        = 2,
    parameter int PRE_CYC        = 2,
    parameter int REFRESH_PERIOD = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              rnw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrdata,
    input  logic [1:0]        bsel,
    output logic              ack,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rddata,
    output logic              busy,
    output logic [ROW_W-1:0]  ma,
    output logic [DATA_W-1:0] dram_dout,
    output logic              dram_doe,
    input  logic [DATA_W-1:0] dram_din,
    output logic              ras_n,
    output logic              ucas_n,
    output logic              lcas_n,
    output logic              we_n
);

    localparam int ACT_CYC = RAS_CYC + CAS_CYC;
    localparam int CNT_W   = $clog2(ACT_CYC + PRE_CYC + 1);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              cnt_done;
    logic              ref_pend, ref_clr, take;

    logic [ADDR_W-1:0] addr_q;
    logic              rnw_q;
    logic [DATA_W-1:0] wrdata_q;
    logic [1:0]        bsel_q;

    logic              ack_nx, rd_valid_nx, busy_nx, doe_nx;
    logic              ras_nx, ucas_nx, lcas_nx, we_nx;
    logic [ROW_W-1:0]  ma_nx;
    logic [DATA_W-1:0] dout_nx, rddata_nx;

    assign cnt_done = (cnt == '0);
    assign ref_clr  = (state == IDLE) && ref_pend;
    assign take     = (state == IDLE) && !ref_pend && req;

    dram_refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh (
        .clk     (clk),
        .rst     (rst),
        .clr     (ref_clr),
        .ref_pend(ref_pend)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b0;
            rd_valid  <= 1'b0;
            rddata    <= '0;
            busy      <= 1'b0;
            ma        <= '0;
            dram_dout <= '0;
            dram_doe  <= 1'b0;
            ras_n     <= 1'b1;
            ucas_n    <= 1'b1;
            lcas_n    <= 1'b1;
            we_n      <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            ack       <= ack_nx;
            rd_valid  <= rd_valid_nx;
            rddata    <= rddata_nx;
            busy      <= busy_nx;
            ma        <= ma_nx;
            dram_dout <= dout_nx;
            dram_doe  <= doe_nx;
            ras_n     <= ras_nx;
            ucas_n    <= ucas_nx;
            lcas_n    <= lcas_nx;
            we_n      <= we_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            addr_q   <= addr;
            rnw_q    <= rnw;
            wrdata_q <= wrdata;
            bsel_q   <= bsel;
        end
    end

    // Each state loads the counter with its length minus one and leaves at zero.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt_done ? '0 : cnt - CNT_W'(1);
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    state_nx = RCAS;
                    cnt_nx   = '0;
                end else if (req) begin
                    state_nx = ROW;
                    cnt_nx   = CNT_W'(RAS_CYC - 1);
                end
            end
            ROW:  if (cnt_done) begin state_nx = COL;  cnt_nx = CNT_W'(CAS_CYC - 1); end
            COL:  if (cnt_done) begin state_nx = PRE;  cnt_nx = CNT_W'(PRE_CYC - 1); end
            PRE:  if (cnt_done) state_nx = IDLE;
            RCAS: if (cnt_done) begin state_nx = RRAS; cnt_nx = CNT_W'(ACT_CYC - 1); end
            RRAS: if (cnt_done) begin state_nx = RPRE; cnt_nx = CNT_W'(PRE_CYC - 1); end
            RPRE: if (cnt_done) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ack_nx      = 1'b0;
        rd_valid_nx = 1'b0;
        rddata_nx   = rddata;
        ma_nx       = ma;
        dout_nx     = dram_dout;
        doe_nx      = dram_doe;
        ras_nx      = ras_n;
        ucas_nx     = ucas_n;
        lcas_nx     = lcas_n;
        we_nx       = we_n;
        busy_nx     = (state_nx != IDLE);
        case (state)
            IDLE: begin
                if (ref_pend) begin
                    ras_nx  = 1'b1;
                    ucas_nx = 1'b0;
                    lcas_nx = 1'b0;
                    we_nx   = 1'b1;
                    doe_nx  = 1'b0;
                end else if (req) begin
                    ack_nx = 1'b1;
                    ma_nx  = addr[ROW_W-1:0];
                    ras_nx = 1'b0;
                end
            end
            ROW: begin
                if (cnt_done) begin
                    ma_nx              = addr_q[ADDR_W-1:ROW_W];
                    {ucas_nx, lcas_nx} = cas_lanes(rnw_q, bsel_q);
                    we_nx              = rnw_q;
                    doe_nx             = !rnw_q;
                    if (!rnw_q)
                        dout_nx = wrdata_q;
                end
            end
            COL: begin
                if (cnt_done) begin
                    if (rnw_q) begin
                        rddata_nx   = dram_din;
                        rd_valid_nx = 1'b1;
                    end
                    ras_nx  = 1'b1;
                    ucas_nx = 1'b1;
                    lcas_nx = 1'b1;
                    we_nx   = 1'b1;
                    doe_nx  = 1'b0;
                end
            end
            RCAS: if (cnt_done) ras_nx = 1'b0;
            RRAS: begin
                if (cnt_done) begin
                    ras_nx  = 1'b1;
                    ucas_nx = 1'b1;
                    lcas_nx = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule
